// File: rtl/maxnet_ctrl.sv
// MAXNET competition controller: sequences the four PUs through MULT/ADD/UPDATE until at most one activation survives.
// Optional iteration limit with a timeout output is enabled by defining MAXNET_TIMEOUT_EN.
module maxnet_ctrl #(
    parameter int MAX_ITER = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    input  logic [31:0] new0,
    input  logic [31:0] new1,
    input  logic [31:0] new2,
    input  logic [31:0] new3,
    input  logic        zero0,
    input  logic        zero1,
    input  logic        zero2,
    input  logic        zero3,
    output logic [31:0] x0,
    output logic [31:0] x1,
    output logic [31:0] x2,
    output logic [31:0] x3,
    output logic        mult_reg_en,
    output logic        add_reg_en,
    output logic        busy,
    output logic        done,
    output logic [1:0]  winner,
    output logic        winner_valid,
    output logic [31:0] winner_value,
    output logic [7:0]  iter_count
`ifdef MAXNET_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        ADD,
        UPDATE,
        DONE
    } state_t;

    state_t      state;
    logic [2:0]  nz;
    logic [1:0]  surv_idx;
    logic [31:0] surv_value;
    logic [7:0]  iter_next;

    // Lowest-indexed live PU is taken as the survivor; it is only used when nz==1.
    always_comb begin
        nz         = {2'b00, ~zero0} + {2'b00, ~zero1} + {2'b00, ~zero2} + {2'b00, ~zero3};
        surv_idx   = 2'd0;
        surv_value = 32'd0;
        if (!zero3) begin
            surv_idx   = 2'd3;
            surv_value = new3;
        end
        if (!zero2) begin
            surv_idx   = 2'd2;
            surv_value = new2;
        end
        if (!zero1) begin
            surv_idx   = 2'd1;
            surv_value = new1;
        end
        if (!zero0) begin
            surv_idx   = 2'd0;
            surv_value = new0;
        end
        iter_next = (iter_count == 8'hFF) ? iter_count : iter_count + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            x0           <= 32'd0;
            x1           <= 32'd0;
            x2           <= 32'd0;
            x3           <= 32'd0;
            mult_reg_en  <= 1'b0;
            add_reg_en   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            winner       <= 2'd0;
            winner_valid <= 1'b0;
            winner_value <= 32'd0;
            iter_count   <= 8'd0;
`ifdef MAXNET_TIMEOUT_EN
            timeout      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        x0           <= in0;
                        x1           <= in1;
                        x2           <= in2;
                        x3           <= in3;
                        iter_count   <= 8'd0;
                        done         <= 1'b0;
                        winner_valid <= 1'b0;
                        winner       <= 2'd0;
                        busy         <= 1'b1;
                        mult_reg_en  <= 1'b1;
`ifdef MAXNET_TIMEOUT_EN
                        timeout      <= 1'b0;
`endif
                        state        <= MULT;
                    end
                end
                MULT: begin
                    mult_reg_en <= 1'b0;
                    add_reg_en  <= 1'b1;
                    state       <= ADD;
                end
                ADD: begin
                    add_reg_en <= 1'b0;
                    state      <= UPDATE;
                end
                UPDATE: begin
                    x0         <= new0;
                    x1         <= new1;
                    x2         <= new2;
                    x3         <= new3;
                    iter_count <= iter_next;
                    if (nz <= 3'd1) begin
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        winner_valid <= (nz == 3'd1);
                        winner       <= (nz == 3'd1) ? surv_idx : 2'd0;
                        winner_value <= (nz == 3'd1) ? surv_value : 32'd0;
                        state        <= DONE;
                    end
`ifdef MAXNET_TIMEOUT_EN
                    else if (int'({24'd0, iter_next}) >= MAX_ITER) begin
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        timeout      <= 1'b1;
                        winner_valid <= 1'b0;
                        winner       <= 2'd0;
                        winner_value <= 32'd0;
                        state        <= DONE;
                    end
`endif
                    else begin
                        mult_reg_en <= 1'b1;
                        state       <= MULT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Randomized and directed bench for maxnet_ctrl; a scripted PU supplies per-iteration new/zero values.
// Define MAXNET_TIMEOUT_EN for both files to exercise the timeout build (MAX_ITER=4).
module tb_maxnet_ctrl;

    localparam int TB_MAX_ITER = 4;
    localparam int MAX_SCRIPT  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in_v  [4];
    logic [31:0] new_v [4];
    logic [3:0]  zero_v;
    logic [31:0] x0, x1, x2, x3;
    logic        mult_reg_en, add_reg_en, busy, done, winner_valid;
    logic [1:0]  winner;
    logic [31:0] winner_value;
    logic [7:0]  iter_count;
    logic        timeout_o;

    logic [31:0] scr_in   [4];
    logic [31:0] scr_new  [MAX_SCRIPT][4];
    logic [3:0]  scr_zero [MAX_SCRIPT];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    maxnet_ctrl #(.MAX_ITER(TB_MAX_ITER)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
        .new0(new_v[0]), .new1(new_v[1]), .new2(new_v[2]), .new3(new_v[3]),
        .zero0(zero_v[0]), .zero1(zero_v[1]), .zero2(zero_v[2]), .zero3(zero_v[3]),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .mult_reg_en(mult_reg_en), .add_reg_en(add_reg_en),
        .busy(busy), .done(done), .winner(winner), .winner_valid(winner_valid),
        .winner_value(winner_value), .iter_count(iter_count)
`ifdef MAXNET_TIMEOUT_EN
        , .timeout(timeout_o)
`endif
    );

`ifndef MAXNET_TIMEOUT_EN
    assign timeout_o = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int liveCount(input logic [3:0] z);
        int n = 0;
        for (int b = 0; b < 4; b++) if (!z[b]) n++;
        return n;
    endfunction

    function automatic logic [31:0] xOut(input int n);
        case (n)
            0: return x0;
            1: return x1;
            2: return x2;
            default: return x3;
        endcase
    endfunction

    task automatic driveGarbage();
        for (int n = 0; n < 4; n++) new_v[n] = $urandom;
        zero_v = 4'($urandom);
    endtask

    task automatic checkAllZero(input string tag);
        for (int n = 0; n < 4; n++) checkOutput($sformatf("%s_x%0d", tag, n), xOut(n), 32'd0);
        checkOutput({tag, "_mult"}, 32'(mult_reg_en), 32'd0);
        checkOutput({tag, "_add"}, 32'(add_reg_en), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_winner"}, 32'(winner), 32'd0);
        checkOutput({tag, "_wvalid"}, 32'(winner_valid), 32'd0);
        checkOutput({tag, "_wvalue"}, winner_value, 32'd0);
        checkOutput({tag, "_iter"}, 32'(iter_count), 32'd0);
        checkOutput({tag, "_timeout"}, 32'(timeout_o), 32'd0);
    endtask

    // Runs one competition from the current script. Behavioural model: the competition stops after the
    // first iteration with at most one live PU (or at the iteration limit in the timeout build); each
    // iteration is three cycles and x shows the values produced by the previous iteration.
    task automatic applyStimulus(input string name);
        int k = 0, live = 0, exp_win = 0, c, ph;
        logic exp_tmo = 1'b0;
        logic [31:0] exp_x [4];
        for (int i = 0; i < MAX_SCRIPT; i++) begin
            live = liveCount(scr_zero[i]);
            k = i + 1;
            if (live <= 1) break;
`ifdef MAXNET_TIMEOUT_EN
            if (k >= TB_MAX_ITER) begin
                exp_tmo = 1'b1;
                break;
            end
`endif
        end
        for (int b = 3; b >= 0; b--) if (!scr_zero[k-1][b]) exp_win = b;

        for (int n = 0; n < 4; n++) in_v[n] = scr_in[n];
        driveGarbage();
        start = 1'b1;
        @(posedge clk); #1;
        for (int e = 0; e <= 3 * k; e++) begin
            c  = e / 3;
            ph = e % 3;
            for (int n = 0; n < 4; n++) exp_x[n] = (c == 0) ? scr_in[n] : scr_new[c-1][n];
            for (int n = 0; n < 4; n++) checkOutput($sformatf("%s_x%0d@%0d", name, n, e), xOut(n), exp_x[n]);
            checkOutput($sformatf("%s_iter@%0d", name, e), 32'(iter_count), 32'(c));
            if (e < 3 * k) begin
                checkOutput($sformatf("%s_busy@%0d", name, e), 32'(busy), 32'd1);
                checkOutput($sformatf("%s_done@%0d", name, e), 32'(done), 32'd0);
                checkOutput($sformatf("%s_mult@%0d", name, e), 32'(mult_reg_en), 32'(ph == 0));
                checkOutput($sformatf("%s_add@%0d", name, e), 32'(add_reg_en), 32'(ph == 1));
                // Only the UPDATE cycle carries the scripted PU result; other cycles get noise.
                if (ph == 2) begin
                    for (int n = 0; n < 4; n++) new_v[n] = scr_new[c][n];
                    zero_v = scr_zero[c];
                end else begin
                    driveGarbage();
                end
                for (int n = 0; n < 4; n++) in_v[n] = $urandom;
                start = ($urandom_range(0, 2) == 0);
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        for (int h = 0; h < 3; h++) begin
            checkOutput($sformatf("%s_done_h%0d", name, h), 32'(done), 32'd1);
            checkOutput($sformatf("%s_busy_h%0d", name, h), 32'(busy), 32'd0);
            checkOutput($sformatf("%s_mult_h%0d", name, h), 32'(mult_reg_en), 32'd0);
            checkOutput($sformatf("%s_iter_h%0d", name, h), 32'(iter_count), 32'(k));
            checkOutput($sformatf("%s_wvalid_h%0d", name, h), 32'(winner_valid),
                        32'(!exp_tmo && live == 1));
            checkOutput($sformatf("%s_winner_h%0d", name, h), 32'(winner),
                        (!exp_tmo && live == 1) ? 32'(exp_win) : 32'd0);
            checkOutput($sformatf("%s_wvalue_h%0d", name, h), winner_value,
                        (!exp_tmo && live == 1) ? scr_new[k-1][exp_win] : 32'd0);
            checkOutput($sformatf("%s_timeout_h%0d", name, h), 32'(timeout_o), 32'(exp_tmo));
            driveGarbage();
            @(posedge clk); #1;
        end
    endtask

    task automatic randomScript();
        for (int n = 0; n < 4; n++) scr_in[n] = $urandom;
        for (int i = 0; i < MAX_SCRIPT; i++) begin
            for (int n = 0; n < 4; n++) scr_new[i][n] = $urandom;
            scr_zero[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom) & 4'($urandom);
        end
        scr_zero[MAX_SCRIPT-1] = ~(4'b0001 << $urandom_range(0, 3));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        for (int n = 0; n < 4; n++) in_v[n] = $urandom;
        driveGarbage();
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Basic convergence: nz=3,2,1 with PU0 surviving at 0.75.
        scr_in = '{32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000};
        for (int i = 0; i < MAX_SCRIPT; i++) scr_new[i] = '{32'h3F400000, 32'h3E000000, 32'h3D800000, 32'h0};
        scr_zero[0] = 4'b1000;
        scr_zero[1] = 4'b1100;
        scr_zero[2] = 4'b1110;
        for (int i = 3; i < MAX_SCRIPT; i++) scr_zero[i] = 4'b1110;
        applyStimulus("basic");

        // All PUs report zero on the first UPDATE; restarted directly from DONE.
        for (int i = 0; i < MAX_SCRIPT; i++) scr_zero[i] = 4'b1111;
        scr_new[0] = '{32'h0, 32'h0, 32'h0, 32'h0};
        applyStimulus("allzero");

`ifdef MAXNET_TIMEOUT_EN
        for (int i = 0; i < MAX_SCRIPT; i++) scr_zero[i] = 4'b1010;
        applyStimulus("timeout");
`endif

        // Reset during ADD of the second iteration.
        randomScript();
        scr_zero[0] = 4'b0000;
        scr_zero[1] = 4'b0000;
        for (int n = 0; n < 4; n++) in_v[n] = scr_in[n];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 0; e < 4; e++) begin
            if (e % 3 == 2) begin
                for (int n = 0; n < 4; n++) new_v[n] = scr_new[e/3][n];
                zero_v = scr_zero[e/3];
            end else begin
                driveGarbage();
            end
            @(posedge clk); #1;
        end
        checkOutput("midrun_add", 32'(add_reg_en), 32'd1);
        checkOutput("midrun_iter", 32'(iter_count), 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        checkAllZero("midrst");
        @(posedge clk); #1;
        checkOutput("midrst_idle", 32'(busy), 32'd0);
        randomScript();
        applyStimulus("after_rst");

        for (int r = 0; r < 20; r++) begin
            randomScript();
            applyStimulus($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/maxnet_ctrl.md
MAXNET_CTRL -- requirements
Module: maxnet_ctrl

Interface
REQ-001 SHALL have parameter MAX_ITER, default 100, iteration limit used only when MAXNET_TIMEOUT_EN is defined.
REQ-002 SHALL have the following ports, clock and reset first, and no others except REQ-021:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a competition.
- in0..in3  in  32 each  initial IEEE-754 single activations.
- new0..new3  in  32 each  new_value from the four PU instances.
- zero0..zero3  in  1 each  Zero_signal from the four PUs; high means newN is zero.
- x0..x3  out  32 each  registered current activations driven to all PUs.
- mult_reg_en  out  1  PU product-register enable.
- add_reg_en  out  1  PU sum-register enable.
- busy  out  1  competition in progress.
- done  out  1  competition finished; result outputs valid.
- winner  out  2  index of the surviving nonzero activation.
- winner_valid  out  1  exactly one survivor exists.
- winner_value  out  32  activation of the winner.
- iter_count  out  8  completed iterations, saturating at 255.

Function
REQ-003 SHALL implement the FSM states IDLE, MULT, ADD, UPDATE and DONE.
REQ-004 In IDLE or DONE with start=1, the block SHALL load x0..x3 <= in0..in3, clear iter_count, done, winner_valid and winner, and go to MULT.
REQ-005 SHALL assert mult_reg_en only while in MULT, for exactly one cycle, then go to ADD.
REQ-006 SHALL assert add_reg_en only while in ADD, for exactly one cycle, then go to UPDATE.
REQ-007 In UPDATE the block SHALL do all of the following:
- latch xN <= newN for N=0..3.
- increment iter_count, saturating at 255.
- compute nz = number of zeroN that are low.
REQ-008 From UPDATE, if nz<=1 the FSM SHALL go to DONE; otherwise it SHALL go to MULT.
REQ-009 Each iteration SHALL take exactly 3 cycles (MULT, ADD, UPDATE).
REQ-010 At least one iteration SHALL always run, even if all inputs are zero.
REQ-011 On entering DONE with nz==1, the block SHALL set the following:
- winner_valid=1.
- winner = index of the low zeroN.
- winner_value = that newN.
REQ-012 On entering DONE with nz==0, the block SHALL set winner_valid=0, winner=0 and winner_value=0.
REQ-013 done SHALL be high in DONE only.
REQ-014 busy SHALL be high in MULT, ADD and UPDATE only.
REQ-015 done and the result outputs SHALL hold until the next accepted start or rst.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 x0..x3 SHALL change only on an accepted start or in UPDATE, and SHALL be stable through MULT and ADD.
REQ-018 zeroN SHALL be sampled only in UPDATE; its value in other states has no effect.

Reset
REQ-019 When rst=1 at a clock edge, including mid-competition, the block SHALL go to IDLE and set every output to 0: x0..x3, mult_reg_en, add_reg_en, busy, done, winner, winner_valid, winner_value, iter_count and timeout.
REQ-020 rst SHALL take priority over start on the same edge.

Configuration
REQ-021 With macro MAXNET_TIMEOUT_EN defined, the block SHALL do all of the following:
- add port timeout (out, 1) to the port list of REQ-002.
- in UPDATE, if iter_count reaches MAX_ITER while nz>1, go to DONE with timeout=1 and winner_valid=0.
- clear timeout on an accepted start.
REQ-022 Without MAXNET_TIMEOUT_EN, the block SHALL have no timeout port, SHALL ignore MAX_ITER and SHALL iterate until nz<=1.

Verification
The bench uses a scripted PU model that returns per-iteration new/zero values.
REQ-023 The bench SHALL cover the following directed scenarios:
- Basic convergence: start with in=3F800000,3F000000,3E800000,3E000000; script nz=3,2,1 with survivor index 0 = 3F400000 -> done=1 after 9 cycles; winner=0, winner_valid=1, winner_value=3F400000, iter_count=3.
- All zero: all zeroN=1 in the first UPDATE -> done after 3 cycles; winner_valid=0, winner_value=0, iter_count=1.
- Enable pulses: during one iteration -> mult_reg_en high exactly 1 cycle, followed immediately by add_reg_en high exactly 1 cycle; x0..x3 unchanged across MULT and ADD.
- Reset mid-run: rst=1 during ADD of iteration 2 -> next cycle every output is 0 and the FSM is in IDLE; a later start runs normally.
- Start while busy: start pulsed during MULT -> ignored, iter_count is not cleared; start while in DONE -> restarts with new inputs.
- Timeout (macro defined, MAX_ITER=4): nz stays 2 -> done=1 and timeout=1 after 12 cycles, winner_valid=0.
